// File: rtl/fc_12_feeder.sv
// Input-side sequencer for the fc_12 core: per neuron it streams a weight burst,
// one idle cycle and an activation burst, then waits for and forwards the result.
`timescale 1ns/1ps
module fc_12_feeder #(
    parameter int N_OUT    = 12,
    parameter int N_W      = 144,
    parameter int N_CYC    = 12,
    parameter int LANES    = 12,
    parameter int WA_W     = 11,
    parameter int AA_W     = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             w_rd_en,
    output logic [WA_W-1:0]  w_rd_addr,
    input  logic             w_rd_data,
    output logic             a_rd_en,
    output logic [AA_W-1:0]  a_rd_addr,
    input  logic [LANES-1:0] a_rd_data,
    output logic             weight_en,
    output logic             weight,
    output logic             ivalid,
    output logic [LANES-1:0] din,
    input  logic             fc_ovalid,
    input  logic [15:0]      fc_dout,
    output logic             res_valid,
    output logic [3:0]       res_idx,
    output logic [15:0]      res_data
);
    localparam int WC_W = $clog2(N_W + 1);
    localparam int TM_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LOADW, GAP, FEED, WAITO, FIN} state_t;

    state_t          state, state_nx;
    logic [WA_W-1:0] wa;
    logic [WC_W-1:0] wcnt;
    logic [AA_W-1:0] k;
    logic [3:0]      n;
    logic [TM_W-1:0] timer;

    logic w_last, k_last, n_last, t_out;

    assign w_last = (wcnt == WC_W'(N_W - 1));
    assign k_last = (k == AA_W'(N_CYC - 1));
    assign n_last = (n == 4'(N_OUT - 1));
    assign t_out  = (timer == TM_W'(WAIT_MAX));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOADW;
            LOADW:   if (w_last) state_nx = GAP;
            GAP:     state_nx = FEED;
            FEED:    if (k_last) state_nx = WAITO;
            WAITO: begin
                if (fc_ovalid)  state_nx = n_last ? FIN : LOADW;
                else if (t_out) state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read strobes come straight from the state; the fc_12 side is the strobe
    // delayed by the one-cycle memory latency, so data and valid line up.
    assign busy      = (state != IDLE) && (state != FIN);
    assign done      = (state == FIN);
    assign w_rd_en   = (state == LOADW);
    assign w_rd_addr = w_rd_en ? wa : '0;
    assign a_rd_en   = (state == FEED);
    assign a_rd_addr = a_rd_en ? k : '0;
    assign weight    = weight_en & w_rd_data;
    assign din       = ivalid ? a_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wa        <= '0;
            wcnt      <= '0;
            k         <= '0;
            n         <= '0;
            timer     <= '0;
            err       <= 1'b0;
            weight_en <= 1'b0;
            ivalid    <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
        end else begin
            state     <= state_nx;
            weight_en <= w_rd_en;
            ivalid    <= a_rd_en;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        n    <= '0;
                        wa   <= '0;
                        wcnt <= '0;
                    end
                end
                LOADW: begin
                    wa   <= wa + 1'b1;
                    wcnt <= w_last ? '0 : wcnt + 1'b1;
                end
                GAP: k <= '0;
                FEED: begin
                    k     <= k_last ? '0 : k + 1'b1;
                    timer <= '0;
                end
                WAITO: begin
                    if (fc_ovalid) begin
                        res_valid <= 1'b1;
                        res_idx   <= n;
                        res_data  <= fc_dout;
                        wcnt      <= '0;
                        if (!n_last) n <= n + 1'b1;
                    end else if (t_out) begin
                        err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
            // A result outside the wait window is flagged; it must win over the start-clear.
            if (fc_ovalid && state != WAITO) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fc_12_feeder.sv
// Directed bench for fc_12_feeder with behavioural weight ROM, activation buffer
// and fc_12 result model; burst structure and results are checked every cycle.
`timescale 1ns/1ps
module tb_fc_12_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic        w_rd_en;
    logic [10:0] w_rd_addr;
    logic        w_rd_data = 1'b0;
    logic        a_rd_en;
    logic [3:0]  a_rd_addr;
    logic [11:0] a_rd_data = '0;
    logic        weight_en, weight, ivalid;
    logic [11:0] din;
    logic        fc_ovalid;
    logic [15:0] fc_dout;
    logic        res_valid;
    logic [3:0]  res_idx;
    logic [15:0] res_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_12_feeder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .weight_en(weight_en), .weight(weight), .ivalid(ivalid), .din(din),
        .fc_ovalid(fc_ovalid), .fc_dout(fc_dout),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memories: one-cycle read latency. Weight bit = addr[0], row k = 1<<k.
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= w_rd_addr[0];
        if (a_rd_en) a_rd_data <= 12'h001 << a_rd_addr;
    end

    // fc_12 model: result 3 cycles after the 12th ivalid of a neuron, dout = n*10-50.
    logic        model_clr = 1'b0;
    logic        fc_spur = 1'b0;
    int          skip_n = -1;
    int          nb = 0;
    int          iv_cnt = 0;
    int          fire_n = 0;
    logic [1:0]  pipe = '0;
    logic        model_ov = 1'b0;
    logic [15:0] model_dout = '0;
    logic        fire;

    assign fire      = ivalid && (iv_cnt == 11) && (nb != skip_n);
    assign fc_ovalid = model_ov | fc_spur;
    assign fc_dout   = model_dout;

    always @(posedge clk) begin
        if (rst || model_clr) begin
            nb       <= 0;
            iv_cnt   <= 0;
            pipe     <= '0;
            model_ov <= 1'b0;
        end else begin
            pipe     <= {pipe[0], fire};
            model_ov <= pipe[1];
            if (fire) fire_n <= nb;
            if (pipe[1]) model_dout <= 16'(fire_n * 10 - 50);
            if (ivalid) begin
                if (iv_cnt == 11) begin
                    iv_cnt <= 0;
                    nb     <= nb + 1;
                end else begin
                    iv_cnt <= iv_cnt + 1;
                end
            end
        end
    end

    // Scoreboard / protocol monitor, sampled on the falling edge.
    logic [19:0] exp_q[$];
    int   exp_wa = 0, ak = 0, we_run = 0, iv_run = 0, idle_run = 0;
    int   we_total = 0, iv_total = 0, done_cnt = 0;
    logic prev_we = 1'b0, prev_iv = 1'b0;

    always @(negedge clk) begin
        logic [11:0] exp_din;
        logic [19:0] exp_res;
        if (rst || model_clr) begin
            exp_wa = 0; ak = 0; we_run = 0; iv_run = 0; idle_run = 0;
            we_total = 0; iv_total = 0; prev_we = 1'b0; prev_iv = 1'b0;
            if (rst) exp_q.delete();
        end else begin
            if (w_rd_en) begin
                check_eq("w_addr", 32'(w_rd_addr), 32'(exp_wa));
                exp_wa++;
            end
            if (a_rd_en) begin
                check_eq("a_addr", 32'(a_rd_addr), 32'(ak));
                ak = (ak == 11) ? 0 : ak + 1;
            end
            if (weight_en || ivalid) check_eq("we_iv_excl", 32'(weight_en & ivalid), 32'd0);
            if (weight_en) begin
                check_eq("weight", 32'(weight), 32'(we_total % 2));
                we_total++;
                we_run++;
            end
            if (!weight_en && prev_we) begin
                check_eq("w_burst_len", 32'(we_run), 32'd144);
                we_run = 0;
                idle_run = 0;
            end
            if (!weight_en && !ivalid) idle_run++;
            if (ivalid && !prev_iv) check_eq("gap_len", 32'(idle_run), 32'd1);
            if (ivalid) begin
                exp_din = 12'h001 << iv_run;
                check_eq("din", 32'(din), 32'(exp_din));
                iv_run++;
                iv_total++;
            end
            if (!ivalid && prev_iv) begin
                check_eq("iv_burst_len", 32'(iv_run), 32'd12);
                iv_run = 0;
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("res_unexpected", {12'd0, res_idx, res_data}, 32'hFFFFFFFF);
                end else begin
                    exp_res = exp_q.pop_front();
                    check_eq("res", {12'd0, res_idx, res_data}, {12'd0, exp_res});
                end
            end
            if (done) done_cnt++;
            prev_we = weight_en;
            prev_iv = ivalid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_results(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back({4'(i), 16'(i * 10 - 50)});
    endtask

    task automatic start_run();
        start = 1'b1;
        model_clr = 1'b1;
        step();
        start = 1'b0;
        model_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ctl"}, {23'd0, busy, done, err, w_rd_en, a_rd_en,
                                 weight_en, weight, ivalid, res_valid}, 32'd0);
        check_eq({tag, "_addr"}, {17'd0, w_rd_addr, a_rd_addr}, 32'd0);
        check_eq({tag, "_din"}, 32'(din), 32'd0);
        check_eq({tag, "_res"}, {12'd0, res_idx, res_data}, 32'd0);
    endtask

    initial begin
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        step();
        check_zero("idle");

        // Full run; an extra start during FEED must be ignored.
        push_results(12);
        start_run();
        check_eq("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 400 && !a_rd_en; i++) step();
        check_eq("feed_reached", 32'(a_rd_en), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(5000);
        check_eq("run1_err", 32'(err), 32'd0);
        step();
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("run1_left", 32'(exp_q.size()), 32'd0);
        check_eq("run1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("run1_we_total", 32'(we_total), 32'd1728);
        check_eq("run1_iv_total", 32'(iv_total), 32'd144);

        // Neuron 2 never answers: timeout abort after two results.
        skip_n = 2;
        push_results(2);
        start_run();
        wait_done(3000);
        check_eq("abort_err", 32'(err), 32'd1);
        step();
        check_eq("abort_left", 32'(exp_q.size()), 32'd0);
        check_eq("abort_done_cnt", 32'(done_cnt), 32'd2);
        check_eq("abort_we_total", 32'(we_total), 32'd432);
        check_eq("abort_iv_total", 32'(iv_total), 32'd36);

        // Restart clears err; a stray fc_ovalid in LOADW sets it without a result.
        skip_n = -1;
        push_results(12);
        start_run();
        check_eq("err_cleared", 32'(err), 32'd0);
        repeat (9) step();
        check_eq("in_loadw", 32'(w_rd_en), 32'd1);
        fc_spur = 1'b1;
        step();
        fc_spur = 1'b0;
        check_eq("spur_err", 32'(err), 32'd1);
        check_eq("spur_no_res", 32'(res_valid), 32'd0);
        wait_done(5000);
        check_eq("spur_err_sticky", 32'(err), 32'd1);
        step();
        check_eq("spur_left", 32'(exp_q.size()), 32'd0);
        check_eq("spur_done_cnt", 32'(done_cnt), 32'd3);

        // Reset in the middle of neuron 5's weight burst.
        push_results(12);
        start_run();
        for (int i = 0; i < 2000 && exp_wa < 5 * 144 + 20; i++) step();
        check_eq("n5_loadw", 32'(w_rd_en), 32'd1);
        rst = 1'b1;
        step();
        check_zero("midrst");
        rst = 1'b0;
        repeat (3) step();
        check_eq("midrst_no_done", 32'(done_cnt), 32'd3);
        push_results(12);
        start_run();
        wait_done(5000);
        check_eq("rerun_err", 32'(err), 32'd0);
        step();
        check_eq("rerun_left", 32'(exp_q.size()), 32'd0);
        check_eq("rerun_done_cnt", 32'(done_cnt), 32'd4);
        check_eq("rerun_we_total", 32'(we_total), 32'd1728);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fc_12_feeder.md
Name: fc_12_feeder

Overview:
Sequencer that drives the input side of the fc_12 fully-connected core. It fetches serial weight bits from a weight memory and 12-lane binary activations from an activation buffer. For each of the N_OUT output neurons it replays fc_12's protocol (weight burst, gap, activation burst), then waits for fc_12's result and forwards it with its neuron index. It sits between the layer-11 output buffer / weight ROM and fc_12.

Parameters:
N_OUT, 12, output neurons per run
N_W, 144, weight bits per neuron (one per weight_en cycle)
N_CYC, 12, activation cycles per neuron (one ivalid cycle each)
LANES, 12, activation lanes (din width)
WA_W, 11, weight address width (must hold N_OUT*N_W-1 = 1727)
AA_W, 4, activation address width (must hold N_CYC-1)
WAIT_MAX, 255, max cycles waiting for fc_ovalid before abort

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle run request
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run (normal or abort)
err  out  1  sticky timeout/protocol error flag; cleared by next accepted start
w_rd_en  out  1  weight memory read strobe
w_rd_addr  out  WA_W  weight bit address
w_rd_data  in  1  weight bit, valid 1 cycle after w_rd_en
a_rd_en  out  1  activation buffer read strobe
a_rd_addr  out  AA_W  activation row address
a_rd_data  in  LANES  activation row, valid 1 cycle after a_rd_en
weight_en  out  1  to fc_12: weight bit valid
weight  out  1  to fc_12: weight bit
ivalid  out  1  to fc_12: activation row valid
din  out  LANES  to fc_12: din_0..din_11 (bit i = din_i)
fc_ovalid  in  1  from fc_12: result valid
fc_dout  in  16  from fc_12: signed neuron sum
res_valid  out  1  one-cycle result strobe
res_idx  out  4  neuron index of result (0..N_OUT-1)
res_data  out  16  signed result

Behaviour:
- Reset: synchronous, active-high. All outputs 0; FSM to IDLE; counters 0; err 0. A reset mid-run aborts immediately, with no done pulse.
- FSM states: IDLE, LOADW, GAP, FEED, WAITO, FIN.
- IDLE: start=1 → busy=1, err=0, neuron n=0, weight address counter wa=0 → LOADW. start while busy is ignored.
- LOADW: w_rd_en=1, w_rd_addr=wa, wa++ every cycle, for N_W cycles. After the N_W-th issue → GAP. wa is not reset between neurons; it runs linearly 0..N_OUT*N_W-1, so neuron n uses addresses n*144..n*144+143.
- GAP: one cycle with no reads issued → FEED.
- FEED: a_rd_en=1, a_rd_addr=k, k=0..N_CYC-1. The same rows are reused for every neuron. After the last issue → WAITO with timer=0.
- Output alignment:
  - weight_en = w_rd_en delayed 1 cycle; weight = w_rd_data when weight_en=1, else 0.
  - ivalid = a_rd_en delayed 1 cycle; din = a_rd_data when ivalid=1, else 0.
  - Result: exactly 144 consecutive weight_en cycles, then exactly 1 idle cycle, then exactly 12 consecutive ivalid cycles. weight_en and ivalid are never high together.
- WAITO: waits for fc_ovalid=1.
  - On fc_ovalid: next cycle res_valid=1, res_idx=n, res_data=fc_dout captured that cycle. If n==N_OUT-1 → FIN; else n++ → LOADW.
  - If timer reaches WAIT_MAX without fc_ovalid: err=1 → FIN.
- fc_ovalid in any state other than WAITO is ignored for results and sets err=1; the run continues.
- FIN: done=1 for one cycle, busy=0 in the same cycle → IDLE.
- Nominal run length, assuming fc_ovalid returns L cycles after the last ivalid: N_OUT*(N_W+1+N_CYC+1+L+1) + O(1) cycles.
- res_data is passed through unmodified; no width change and no saturation.

Test Plan:
- Reset, then start. Weight memory returns bit = addr[0]; activation row k = 12'h001<<k; fc model returns ovalid 3 cycles after last ivalid with dout = 16'sd(n*10-50). Expect 12 bursts of 144 weight_en, 1 gap, 12 ivalid; addresses 0..1727; res_idx 0..11 with res_data -50,-40,..,60; one done pulse; err=0.
- Per-burst alignment check: weight on the k-th weight_en of neuron n equals memory bit at address n*144+k; din on the k-th ivalid equals row k; no cycle has weight_en and ivalid both high.
- fc model never asserts ovalid for neuron 2: after WAIT_MAX=255 cycles, err=1 and done pulses. Expect res_valid only for idx 0 and 1; next start clears err.
- Spurious fc_ovalid during LOADW of neuron 0: err=1 and no res_valid at that point; all 12 results are still produced normally.
- start pulsed again during FEED: ignored; addresses and counts unchanged.
- rst asserted during LOADW of neuron 5: all outputs 0 on the next cycle, no done pulse; a fresh start restarts at w_rd_addr 0, neuron 0.
